// File: rtl/simple_cpu_param.sv
// Multi-cycle 8-register CPU with a DATA_W-bit datapath, shift modes
// LSL/LSR/ASR, optional all-op flag update and a sticky illegal flag.
// Ports: clk, rst_n (sync, active low); load/start/instr handshake in;
// waiting (idle), out (last ALU/MOV result), N/V/Z flags, illegal out.
module simple_cpu_param #(
  parameter int DATA_W    = 16,
  parameter bit FLAGS_ALL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              start,
  input  logic [15:0]       instr,
  output logic              waiting,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_FETCH_A,
    S_FETCH_B,
    S_EXEC_WB
  } state_t;

  localparam int M = DATA_W - 1;

  state_t            state, state_nx;
  logic [15:0]       ir;
  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] a_q, b_q;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic [7:0] im8;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign im8    = ir[7:0];

  assign waiting = (state == S_WAIT);

  logic [DATA_W-1:0] rm_val, rm_sh;

  assign rm_val = rf[rm];

  always_comb begin
    rm_sh = rm_val;
    unique case (sh)
      2'b00: rm_sh = rm_val;
      2'b01: rm_sh = {rm_val[M-1:0], 1'b0};
      2'b10: rm_sh = {1'b0, rm_val[M:1]};
      2'b11: rm_sh = {rm_val[M], rm_val[M:1]};
      default: rm_sh = rm_val;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_WAIT:    if (start) state_nx = S_DECODE;
      S_DECODE:  state_nx = S_FETCH_A;
      S_FETCH_A: state_nx = S_FETCH_B;
      S_FETCH_B: state_nx = S_EXEC_WB;
      S_EXEC_WB: state_nx = S_WAIT;
      default:   state_nx = S_WAIT;
    endcase
  end

  logic [DATA_W-1:0] res, sub;
  logic [2:0]        wr_addr;
  logic              wr_en, wr_out, upd, v_new, bad;

  always_comb begin
    res     = '0;
    sub     = a_q - b_q;
    wr_addr = rd;
    wr_en   = 1'b0;
    wr_out  = 1'b0;
    upd     = 1'b0;
    v_new   = 1'b0;
    bad     = 1'b0;
    unique case (1'b1)
      (opcode == 3'b110 && op == 2'b10): begin
        res     = {{(DATA_W-8){im8[7]}}, im8};
        wr_addr = rn;
        wr_en   = 1'b1;
      end
      (opcode == 3'b110 && op == 2'b00): begin
        res    = b_q;
        wr_en  = 1'b1;
        wr_out = 1'b1;
        upd    = FLAGS_ALL;
      end
      (opcode == 3'b101 && op == 2'b00): begin
        res    = a_q + b_q;
        wr_en  = 1'b1;
        wr_out = 1'b1;
        upd    = FLAGS_ALL;
      end
      (opcode == 3'b101 && op == 2'b01): begin
        res   = sub;
        upd   = 1'b1;
        // operands of opposite sign and result sign flipped from Rn
        v_new = (a_q[M] ^ b_q[M]) & (sub[M] ^ a_q[M]);
      end
      (opcode == 3'b101 && op == 2'b10): begin
        res    = a_q & b_q;
        wr_en  = 1'b1;
        wr_out = 1'b1;
        upd    = FLAGS_ALL;
      end
      (opcode == 3'b101 && op == 2'b11): begin
        res    = ~b_q;
        wr_en  = 1'b1;
        wr_out = 1'b1;
        upd    = FLAGS_ALL;
      end
      default: bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_WAIT;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out     <= '0;
      N       <= 1'b0;
      V       <= 1'b0;
      Z       <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == S_WAIT && load) ir <= instr;
      if (state == S_FETCH_A) a_q <= rf[rn];
      if (state == S_FETCH_B) b_q <= rm_sh;
      if (state == S_EXEC_WB) begin
        if (wr_en)  rf[wr_addr] <= res;
        if (wr_out) out <= res;
        if (upd) begin
          N <= res[M];
          V <= v_new;
          Z <= (res == '0);
        end
        if (bad) illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_simple_cpu_param.sv
// Directed bench for simple_cpu_param: a 16-bit/CMP-only-flags instance
// and a 32-bit/all-flags instance, driven from vector tables.
module tb_simple_cpu_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ld16, st16, ld32, st32;
  logic [15:0] in16, in32;
  logic        wt16, wt32, n16, v16, z16, n32, v32, z32, il16, il32;
  logic [15:0] o16;
  logic [31:0] o32;

  simple_cpu_param #(.DATA_W(16), .FLAGS_ALL(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .load(ld16), .start(st16),
    .instr(in16), .waiting(wt16), .out(o16),
    .N(n16), .V(v16), .Z(z16), .illegal(il16)
  );

  simple_cpu_param #(.DATA_W(32), .FLAGS_ALL(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .load(ld32), .start(st32),
    .instr(in32), .waiting(wt32), .out(o32),
    .N(n32), .V(v32), .Z(z32), .illegal(il32)
  );

  logic        sel;
  logic        c_wait, c_ill;
  logic [31:0] c_out;
  logic [2:0]  c_nvz;

  assign c_wait = sel ? wt32 : wt16;
  assign c_ill  = sel ? il32 : il16;
  assign c_out  = sel ? o32 : {16'h0, o16};
  assign c_nvz  = sel ? {n32, v32, z32} : {n16, v16, z16};

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] ins;
    logic [31:0] out;
    logic [2:0]  nvz;
    logic        ill;
  } vec_t;

  vec_t t16[30];
  vec_t t32[9];

  localparam logic [1:0] S0 = 2'b00, LSL = 2'b01;
  localparam logic [1:0] LSR = 2'b10, ASR = 2'b11;

  function automatic logic [15:0] movi(input logic [2:0] n,
                                       input logic [7:0] im);
    return {3'b110, 2'b10, n, im};
  endfunction

  function automatic logic [15:0] alu(input logic [1:0] op,
      input logic [2:0] rn, input logic [2:0] rd,
      input logic [1:0] sh, input logic [2:0] rm);
    return {3'b101, op, rn, rd, sh, rm};
  endfunction

  function automatic logic [15:0] mov(input logic [2:0] rd,
      input logic [1:0] sh, input logic [2:0] rm);
    return {3'b110, 2'b00, 3'b000, rd, sh, rm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic l, input logic s,
                     input logic [15:0] i);
    if (sel) begin
      ld32 = l; st32 = s; in32 = i;
    end else begin
      ld16 = l; st16 = s; in16 = i;
    end
  endtask

  // issue one instruction; lat = idle-low cycles seen after start
  task automatic run(input logic [15:0] ins, input logic l,
                     output int lat);
    @(negedge clk);
    drv(l, 1'b1, ins);
    @(posedge clk);
    @(negedge clk);
    drv(1'b0, 1'b0, 16'h0);
    lat = 0;
    while (!c_wait && lat < 20) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic chk_state(input string nm, input logic [31:0] o,
                           input logic [2:0] nvz, input logic il);
    chk({nm, " out"}, c_out, o);
    chk({nm, " nvz"}, {29'h0, c_nvz}, {29'h0, nvz});
    chk({nm, " ill"}, {31'h0, c_ill}, {31'h0, il});
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    sel = 1'b0;
    ld16 = 0; st16 = 0; in16 = 0;
    ld32 = 0; st32 = 0; in32 = 0;

    t16[0]  = '{movi(0, 8'h45), 32'h0000, 3'b000, 1'b0};
    t16[1]  = '{movi(1, 8'hBB), 32'h0000, 3'b000, 1'b0};
    t16[2]  = '{alu(2'b00, 0, 7, S0, 1), 32'h0000, 3'b000, 1'b0};
    t16[3]  = '{mov(2, LSL, 0), 32'h008A, 3'b000, 1'b0};
    t16[4]  = '{mov(0, LSL, 0), 32'h008A, 3'b000, 1'b0};
    t16[5]  = '{alu(2'b01, 0, 0, S0, 2), 32'h008A, 3'b001, 1'b0};
    t16[6]  = '{movi(6, 8'h73), 32'h008A, 3'b001, 1'b0};
    t16[7]  = '{mov(6, LSL, 6), 32'h00E6, 3'b001, 1'b0};
    t16[8]  = '{mov(6, LSL, 6), 32'h01CC, 3'b001, 1'b0};
    t16[9]  = '{mov(6, LSL, 6), 32'h0398, 3'b001, 1'b0};
    t16[10] = '{mov(6, LSL, 6), 32'h0730, 3'b001, 1'b0};
    t16[11] = '{mov(6, LSL, 6), 32'h0E60, 3'b001, 1'b0};
    t16[12] = '{mov(6, LSL, 6), 32'h1CC0, 3'b001, 1'b0};
    t16[13] = '{mov(6, LSL, 6), 32'h3980, 3'b001, 1'b0};
    t16[14] = '{mov(6, LSL, 6), 32'h7300, 3'b001, 1'b0};
    t16[15] = '{movi(5, 8'h40), 32'h7300, 3'b001, 1'b0};
    t16[16] = '{alu(2'b00, 6, 6, LSL, 5), 32'h7380, 3'b001, 1'b0};
    t16[17] = '{alu(2'b11, 0, 5, S0, 6), 32'h8C7F, 3'b001, 1'b0};
    t16[18] = '{movi(4, 8'h01), 32'h8C7F, 3'b001, 1'b0};
    t16[19] = '{alu(2'b00, 5, 5, S0, 4), 32'h8C80, 3'b001, 1'b0};
    t16[20] = '{alu(2'b01, 6, 0, S0, 5), 32'h8C80, 3'b110, 1'b0};
    t16[21] = '{alu(2'b01, 5, 0, S0, 6), 32'h8C80, 3'b010, 1'b0};
    t16[22] = '{movi(3, 8'h80), 32'h8C80, 3'b010, 1'b0};
    t16[23] = '{mov(4, LSR, 3), 32'h7FC0, 3'b010, 1'b0};
    t16[24] = '{mov(4, ASR, 3), 32'hFFC0, 3'b010, 1'b0};
    t16[25] = '{alu(2'b11, 0, 4, S0, 3), 32'h007F, 3'b010, 1'b0};
    t16[26] = '{16'hE084, 32'h007F, 3'b010, 1'b1};
    t16[27] = '{mov(7, S0, 4), 32'h007F, 3'b010, 1'b1};
    t16[28] = '{16'hC884, 32'h007F, 3'b010, 1'b1};
    t16[29] = '{alu(2'b10, 3, 7, S0, 4), 32'h0000, 3'b010, 1'b1};

    t32[0] = '{movi(0, 8'hFF), 32'h0, 3'b000, 1'b0};
    t32[1] = '{alu(2'b00, 0, 1, S0, 0), 32'hFFFFFFFE, 3'b100, 1'b0};
    t32[2] = '{alu(2'b10, 0, 2, S0, 1), 32'hFFFFFFFE, 3'b100, 1'b0};
    t32[3] = '{movi(3, 8'h01), 32'hFFFFFFFE, 3'b100, 1'b0};
    t32[4] = '{mov(4, LSL, 3), 32'h00000002, 3'b000, 1'b0};
    t32[5] = '{alu(2'b11, 0, 5, S0, 0), 32'h00000000, 3'b001, 1'b0};
    t32[6] = '{alu(2'b01, 3, 0, S0, 4), 32'h00000000, 3'b100, 1'b0};
    t32[7] = '{mov(6, LSR, 0), 32'h7FFFFFFF, 3'b000, 1'b0};
    t32[8] = '{mov(6, ASR, 0), 32'hFFFFFFFF, 3'b100, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      chk($sformatf("rst%0d wait", d), {31'h0, c_wait}, 32'h1);
      chk_state($sformatf("rst%0d", d), 32'h0, 3'b000, 1'b0);
    end
    rst_n = 1'b1;

    sel = 1'b0;
    for (int i = 0; i < 30; i++) begin
      run(t16[i].ins, 1'b1, lat);
      chk($sformatf("v16[%0d] lat", i), lat, 4);
      chk_state($sformatf("v16[%0d]", i), t16[i].out,
                t16[i].nvz, t16[i].ill);
    end

    // load alone must not start; start alone re-runs IR
    @(negedge clk);
    drv(1'b1, 1'b0, mov(0, LSL, 0));
    @(posedge clk);
    @(negedge clk);
    drv(1'b0, 1'b0, 16'h0);
    chk("load-only wait", {31'h0, c_wait}, 32'h1);
    chk("load-only out", c_out, 32'h0000);
    run(16'hFFFF, 1'b0, lat);
    chk("rerun1 lat", lat, 4);
    chk("rerun1 out", c_out, 32'h0114);
    run(16'hFFFF, 1'b0, lat);
    chk("rerun2 out", c_out, 32'h0228);

    // load+start pulsed while busy are ignored
    @(negedge clk);
    drv(1'b0, 1'b1, 16'h0);
    @(posedge clk);
    @(negedge clk);
    drv(1'b1, 1'b1, alu(2'b11, 0, 0, S0, 0));
    lat = 0;
    while (!c_wait && lat < 20) begin
      lat++;
      if (lat == 3) drv(1'b0, 1'b0, 16'h0);
      @(negedge clk);
    end
    chk("busy lat", lat, 4);
    chk("busy out", c_out, 32'h0450);
    @(posedge clk);
    @(negedge clk);
    chk("busy noqueue", {31'h0, c_wait}, 32'h1);
    chk("busy out hold", c_out, 32'h0450);
    run(16'h0, 1'b0, lat);
    chk("ir kept", c_out, 32'h08A0);

    sel = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run(t32[i].ins, 1'b1, lat);
      chk($sformatf("v32[%0d] lat", i), lat, 4);
      chk_state($sformatf("v32[%0d]", i), t32[i].out,
                t32[i].nvz, t32[i].ill);
    end

    // reset while ADD R7,R0,R0 is in FETCH_B
    @(negedge clk);
    drv(1'b1, 1'b1, alu(2'b00, 0, 7, S0, 0));
    @(posedge clk);
    @(negedge clk);
    drv(1'b0, 1'b0, 16'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst wait", {31'h0, c_wait}, 32'h1);
    chk_state("midrst", 32'h0, 3'b000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst idle", {31'h0, c_wait}, 32'h1);
    run(mov(6, S0, 7), 1'b1, lat);
    chk("midrst r7", c_out, 32'h0);
    sel = 1'b0;
    #1;
    chk("rst16 ill", {31'h0, c_ill}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end want end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/simple_cpu_param.md
Name: simple_cpu_param

Overview:
- Parametrised successor of the lab CPU: a multi-cycle, 8-register, 16-bit-instruction CPU with a configurable datapath width DATA_W.
- Adds right shifts (LSR/ASR), a selectable flag-update policy and sticky illegal-instruction detection.
- Driven by the same load/start/waiting handshake. Sits standalone under a bench or board top.

Parameters:
- DATA_W, 16, datapath/register/out width; must be at least 9.
- FLAGS_ALL, 0, 0 means only CMP updates N/V/Z; 1 means every ADD/CMP/AND/MVN/MOV-shift updates N/V/Z.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- load  input  1  capture instr into the instruction register (IR).
- start  input  1  begin executing IR.
- instr  input  16  instruction word.
- waiting  output  1  high when idle and ready for load/start.
- out  output  DATA_W  last value written by a MOV-shift/ADD/AND/MVN.
- N  output  1  negative flag.
- V  output  1  signed-overflow flag.
- Z  output  1  zero flag.
- illegal  output  1  sticky flag, set when an undefined instruction executes.

Behaviour:
- Reset (synchronous, rst_n low at a rising edge): state WAIT, waiting=1, out=0, N=V=Z=0, illegal=0, IR=0, R0..R7=0. Reset mid-instruction aborts it with no register, out or flag write.
- Fields: opcode=instr[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0], im8=[7:0].
- Shifter, applied to Rm only:
  - sh 00: unchanged.
  - sh 01: LSL 1, LSB=0.
  - sh 10: LSR 1, MSB=0.
  - sh 11: ASR 1, MSB preserved.
- Instructions:
  - 110/10 MOV imm: Rn <= sign-extend(im8) to DATA_W. out and flags untouched.
  - 110/00 MOV: Rd <= sh(Rm). Writes out.
  - 101/00 ADD: Rd <= Rn + sh(Rm), modulo 2^DATA_W. Writes out.
  - 101/01 CMP: computes Rn - sh(Rm) and updates N/V/Z. No register or out write.
  - 101/10 AND: Rd <= Rn & sh(Rm). Writes out.
  - 101/11 MVN: Rd <= ~sh(Rm). Writes out.
  - Any other opcode/op: NOP that sets illegal=1. illegal clears only on reset.
- Flags:
  - N = result MSB. Z = (result==0).
  - V is defined for CMP only: operand signs differ and the result sign differs from Rn.
  - For non-CMP updates under FLAGS_ALL=1, V=0.
- FSM: WAIT -> DECODE -> FETCH_A -> FETCH_B -> EXEC_WB -> WAIT.
  - Latency is fixed for every instruction, including MOV imm and NOP.
  - start sampled high in WAIT at edge E0: waiting=0 after E0. The write-back, out and flag updates land at E4, and waiting=1 after E4.
  - Edges E1-E3 cause no architectural change.
- Handshake:
  - load and start are honoured only in WAIT. While waiting=0 both are ignored, and IR is stable for the whole instruction.
  - load and start high together in WAIT: IR takes instr and the new instruction executes.
  - start with no prior load re-executes the current IR.
- Register file: 8 x DATA_W, one write port. Reads in FETCH_A/FETCH_B see all completed prior writes, including Rd==Rn==Rm aliasing.
- out holds its value between writes and is never X after reset.

Test Plan:
- DATA_W=16, FLAGS_ALL=0: MOVimm R0=69, R1=-69; ADD R7,R0,R1 -> out=0, flags stay 0/0/0; MOV R2,R0,LSL1 -> out=138; CMP R0(138),R2 -> N=0 V=0 Z=1, out unchanged at 138.
- Overflow: R6=0x7380 (29568), R5=0x8C80 (-29568). CMP R6,R5 -> N=1 V=1 Z=0; CMP R5,R6 -> N=0 V=1 Z=0.
- Shifts: R3=MOVimm 0x80 (=0xFF80). MOV R4,R3,LSR -> 0x7FC0; MOV R4,R3,ASR -> 0xFFC0; MVN R4,R3 -> 0x007F.
- Handshake: waiting=0 for exactly 4 cycles after start. load/start pulsed mid-instruction -> ignored and IR unchanged. Opcode 111 -> illegal=1, registers and out unchanged, waiting returns after 4 cycles.
- DATA_W=32, FLAGS_ALL=1:
  - MOVimm R0=0xFF -> 0xFFFFFFFF.
  - ADD R1,R0,R0 -> 0xFFFFFFFE, N=1 Z=0 V=0.
  - AND R2,R0,R1 with sh=00 (R2 = R0 & R1) -> 0xFFFFFFFE.
  - MOVimm R3=1; MOV R4,R3,LSL1 -> out=2, N=0, Z=0.
- Reset mid-instruction: assert rst_n=0 during FETCH_B of ADD -> Rd not written, out=0, all flags 0, waiting=1 one cycle after release.
